// File: rtl/ro_odometer_ctrl_if.sv
// Control/readout bus between the odometer controller and the scan logic.
// The requester drives START/STOP/MODE/CH_SEL/WIN_LEN and the controller returns status.
interface ro_odometer_ctrl_if #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 16,
  parameter int WIN_W = 20
);
  localparam int CH_W = $clog2(N_CH);

  logic             START;
  logic             STOP;
  logic             MODE;
  logic [CH_W-1:0]  CH_SEL;
  logic [WIN_W-1:0] WIN_LEN;
  logic             BUSY;
  logic             DONE;
  logic [CNT_W-1:0] COUNT;
  logic             OVF;
  logic             ERR;

  modport master (
    output START, STOP, MODE, CH_SEL, WIN_LEN,
    input  BUSY, DONE, COUNT, OVF, ERR
  );

  modport slave (
    input  START, STOP, MODE, CH_SEL, WIN_LEN,
    output BUSY, DONE, COUNT, OVF, ERR
  );
endinterface

// File: rtl/ro_odometer_ctrl.sv
// Ring-oscillator aging odometer: stress all chains or count one chain's edges.
// Define ODO_DUAL_EDGE_EN to count both rising and falling edges.
module ro_odometer_ctrl #(
  parameter int N_CH        = 8,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 20,
  parameter int SETTLE_CYC  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                CLK,
  input  logic                RSTN,
  ro_odometer_ctrl_if.slave   bus,
  input  logic [N_CH-1:0]     RO_IN,
  output logic [N_CH-1:0]     RO_EN
);
  localparam int CH_W  = $clog2(N_CH);
  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_STRESS = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_COUNT  = 3'd3;
  localparam logic [2:0] S_FINISH = 3'd4;

  logic [2:0]       state, nstate;
  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [CH_W-1:0]  ch_q, ch_nxt;
  logic [WIN_W-1:0] win_q, win_cnt;
  logic [SET_W-1:0] set_cnt;
  logic [CNT_W-1:0] edge_cnt, count_q;
  logic             prev_q, sat_q, ovf_q, err_q;
  logic             ro_s, edge_hit;
  logic             ch_ok, go_meas, go_bad, go_stress;
  logic [N_CH-1:0]  en_nxt;

  assign ro_s  = sync_q[SYNC_STAGES-1][ch_q];
  assign ch_ok = 32'(bus.CH_SEL) < N_CH;

`ifdef ODO_DUAL_EDGE_EN
  assign edge_hit = prev_q ^ ro_s;
`else
  assign edge_hit = ~prev_q & ro_s;
`endif

  assign go_stress = (state == S_IDLE) & bus.START & bus.MODE;
  assign go_meas   = (state == S_IDLE) & bus.START & ~bus.MODE & ch_ok;
  assign go_bad    = (state == S_IDLE) & bus.START & ~bus.MODE & ~ch_ok;

  always_comb begin
    nstate = state;
    unique case (1'b1)
      state == S_IDLE: begin
        if (go_stress)    nstate = S_STRESS;
        else if (go_meas) nstate = S_SETTLE;
      end
      state == S_STRESS: begin
        if (bus.STOP) nstate = S_IDLE;
      end
      state == S_SETTLE: begin
        if (set_cnt == '0)
          nstate = (win_q == '0) ? S_FINISH : S_COUNT;
      end
      state == S_COUNT: begin
        if (win_cnt == '0) nstate = S_FINISH;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Enables are registered from the next state so they track it cycle-exact.
  always_comb begin
    ch_nxt = (state == S_IDLE) ? bus.CH_SEL : ch_q;
    en_nxt = '0;
    if (nstate == S_STRESS)
      en_nxt = '1;
    else if (nstate == S_SETTLE || nstate == S_COUNT)
      en_nxt = N_CH'(1) << ch_nxt;
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= RO_IN;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state    <= S_IDLE;
      RO_EN    <= '0;
      ch_q     <= '0;
      win_q    <= '0;
      win_cnt  <= '0;
      set_cnt  <= '0;
      edge_cnt <= '0;
      count_q  <= '0;
      prev_q   <= 1'b0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state <= nstate;
      RO_EN <= en_nxt;
      if (go_stress) err_q <= 1'b0;
      if (go_bad)    err_q <= 1'b1;
      if (go_meas) begin
        ch_q     <= bus.CH_SEL;
        win_q    <= bus.WIN_LEN;
        set_cnt  <= SET_W'(SETTLE_CYC - 1);
        edge_cnt <= '0;
        sat_q    <= 1'b0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
        err_q    <= 1'b0;
      end
      if (state == S_SETTLE) begin
        prev_q  <= ro_s;
        win_cnt <= win_q - WIN_W'(1);
        if (set_cnt != '0) set_cnt <= set_cnt - SET_W'(1);
      end
      if (state == S_COUNT) begin
        prev_q  <= ro_s;
        win_cnt <= win_cnt - WIN_W'(1);
        if (edge_hit) begin
          if (edge_cnt == '1) sat_q <= 1'b1;
          else                edge_cnt <= edge_cnt + CNT_W'(1);
        end
      end
      if (state == S_FINISH) begin
        count_q <= edge_cnt;
        ovf_q   <= sat_q;
      end
    end
  end

  assign bus.BUSY  = (state != S_IDLE);
  assign bus.DONE  = (state == S_FINISH);
  assign bus.COUNT = count_q;
  assign bus.OVF   = ovf_q;
  assign bus.ERR   = err_q;
endmodule
